action_menu: RTL
================

# action_menu

Converts the three raw pet buttons (select, confirm, cancel) into single-cycle care-action pulses on the 8-bit `inputs` bus of the stats block. Each button is synchronized and debounced. A small menu state machine moves a cursor over the six care actions and fires the selected one on confirm. An optional cooldown blocks rapid repeated actions.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required before a debounced level changes; legal range 2..255.
- `COOLDOWN_CYCLES`, default 64: length of the post-fire lockout; legal range 1..1023; used only when `ACTION_COOLDOWN_EN` is defined.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `btn_raw` in 3: asynchronous raw buttons, active high; [0]=select, [1]=confirm, [2]=cancel.
- `actions` out 8: one-hot, one-cycle action pulse to stats `inputs`; bits [5:0] are used, bits [7:6] are tied to 0.
- `cursor` out 3: currently highlighted action index, 0..5.
- `menu_active` out 1: high in BROWSE, FIRE and COOLDOWN.
- `busy` out 1: high only in COOLDOWN.

## Operation
- Reset: all sync flops, debounced levels, counters, `actions`, `cursor`, `menu_active` and `busy` are 0. The state is IDLE.
- Synchronizer: a 2-flop synchronizer per button.
- Debouncer, per button:
  - A counter increments each cycle while the synchronized level differs from the debounced level. It clears to 0 whenever they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level toggles and the counter clears.
  - Press event: registered, one cycle, on a debounced 0->1 transition. Releases generate no event.
- Simultaneous press events in one cycle are resolved with priority cancel > confirm > select. Only the winner acts; the others are dropped.
- FSM states:
  - IDLE:
    - `cursor`=0.
    - select -> BROWSE, `cursor` stays 0.
    - confirm and cancel are ignored.
  - BROWSE:
    - select -> `cursor`+1; 5 wraps to 0.
    - confirm -> FIRE.
    - cancel -> IDLE, `cursor` cleared.
  - FIRE: lasts exactly one cycle.
    - `actions[cursor]`=1.
    - Next state is COOLDOWN if `ACTION_COOLDOWN_EN` is defined, else BROWSE.
    - `cursor` is retained.
  - COOLDOWN:
    - The counter loads `COOLDOWN_CYCLES`-1 on entry and decrements each cycle. At 0 the FSM returns to BROWSE.
    - All press events in this state, including cancel, are discarded, not queued.
- Action index map: 0 feed (hunger), 1 play (happiness), 2 medicine (health), 3 clean (hygiene), 4 sleep (energy), 5 socialize (social).
- A button held through reset release produces a press event once debounced. This is intended.

## Timing
- All outputs are registered.
- A raw 0->1 edge that is stable from clock edge k produces a press event high in cycle k+2+`DEBOUNCE_CYCLES`. The bench checks this with a tolerance of ±1 cycle for synchronizer phase.
- A confirm press event in cycle N while in BROWSE drives `actions` high during cycle N+1 only. `actions` is 0 in all other cycles.
- A select press in cycle N updates `cursor` in cycle N+1.
- With cooldown: COOLDOWN covers cycles N+2 .. N+1+`COOLDOWN_CYCLES`, and BROWSE resumes at N+2+`COOLDOWN_CYCLES`.
- Without cooldown: BROWSE resumes at N+2.
- Asserting `reset` at any point, including during FIRE, immediately forces the reset values; any in-flight pulse is lost.
- At most one bit of `actions` is high in any cycle.

## Configuration
- `ACTION_COOLDOWN_EN`:
  - Defined: the FIRE->COOLDOWN path, the cooldown counter and `busy` are implemented.
  - Undefined: FIRE returns directly to BROWSE, no counter is built, and `busy` is tied to 0. `COOLDOWN_CYCLES` is ignored.

## Structure
- Package `tama_pkg` holds:
  - the state enum (IDLE, BROWSE, FIRE, COOLDOWN);
  - button index constants BTN_SELECT=0, BTN_CONFIRM=1, BTN_CANCEL=2;
  - action index constants ACT_FEED..ACT_SOCIAL = 0..5 and NUM_ACTIONS=6.
  - The stats block uses the same action constants.
- Sub-module `btn_debounce`: synchronizer, debounce counter and press-event register for one button, parameterized by `DEBOUNCE_CYCLES`. It is instantiated three times.

## Test plan
- Bounce rejection: `btn_raw[0]` toggles every 5 cycles for 100 cycles, then is held high; DEBOUNCE_CYCLES=16 -> exactly one select event, `menu_active`=1, `cursor`=0.
- Cursor wrap: enter BROWSE, then 6 clean select presses -> `cursor` steps through 1,2,3,4,5,0.
- Fire: `cursor`=4, confirm -> `actions`=8'h10 for exactly one cycle, one cycle after the press event. With the macro, `busy`=1 for 64 cycles, and a confirm during that window produces no pulse.
- Priority: in BROWSE, confirm and cancel debounce in the same cycle -> state IDLE, `cursor`=0, `actions` stays 0.
- Reset mid-operation: assert `reset` in the FIRE cycle -> `actions`, `cursor`, `menu_active` and `busy` are all 0 immediately. After release with the button held, one select event occurs and the state is BROWSE.
- Build without `ACTION_COOLDOWN_EN`: two confirms spaced 3 cycles apart -> two pulses; `busy` stays 0 throughout.

Source files
------------

// File: rtl/tama_pkg.sv
// rtl/tama_pkg.sv - shared menu states, button and care-action indices for the pet blocks
package tama_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BROWSE   = 2'd1,
        ST_FIRE     = 2'd2,
        ST_COOLDOWN = 2'd3
    } menu_state_e;

    localparam int NUM_BTNS    = 3;
    localparam int BTN_SELECT  = 0;
    localparam int BTN_CONFIRM = 1;
    localparam int BTN_CANCEL  = 2;

    localparam int ACT_FEED      = 0;  // hunger
    localparam int ACT_PLAY      = 1;  // happiness
    localparam int ACT_MEDICINE  = 2;  // health
    localparam int ACT_CLEAN     = 3;  // hygiene
    localparam int ACT_SLEEP     = 4;  // energy
    localparam int ACT_SOCIALIZE = 5;  // social
    localparam int NUM_ACTIONS   = 6;

    // Advance the cursor, wrapping after the last care action.
    function automatic logic [2:0] cursor_next(input logic [2:0] cur);
        return (cur == 3'(NUM_ACTIONS - 1)) ? 3'd0 : cur + 3'd1;
    endfunction

    // One-hot pulse pattern for an action index; out-of-range indices give no pulse.
    function automatic logic [7:0] action_onehot(input logic [2:0] idx);
        logic [7:0] r;
        r = 8'd0;
        if (int'(idx) < NUM_ACTIONS) begin
            r[idx] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, stability counter and press-event register for one button
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic       level_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       press_q;
    logic       press_d;

    // Count consecutive samples that disagree with the debounced level; the level flips
    // on the DEBOUNCE_CYCLES-th disagreeing sample, and a rising flip is a press.
    always_comb begin
        level_d = level_q;
        cnt_d   = 8'd0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
        press_d = level_d & ~level_q;
    end

    // Synchronizer, debounce state and registered press event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= 8'd0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/action_menu.sv
// rtl/action_menu.sv - button-driven care-action menu; optional cooldown via ACTION_COOLDOWN_EN
module action_menu
    import tama_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COOLDOWN_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn_raw,
    output logic [7:0] actions,
    output logic [2:0] cursor,
    output logic       menu_active,
    output logic       busy
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("action_menu: DEBOUNCE_CYCLES out of range 2..255");
    end
    if (COOLDOWN_CYCLES < 1 || COOLDOWN_CYCLES > 1023) begin : g_bad_cooldown
        $error("action_menu: COOLDOWN_CYCLES out of range 1..1023");
    end

    logic [NUM_BTNS-1:0] press;

    for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i  (clk),
            .rst_i  (reset),
            .btn_i  (btn_raw[b]),
            .press_o(press[b])
        );
    end

    // Cancel beats confirm beats select; losers in the same cycle are dropped.
    logic cancel_ev;
    logic confirm_ev;
    logic select_ev;
    assign cancel_ev  = press[BTN_CANCEL];
    assign confirm_ev = press[BTN_CONFIRM] & ~press[BTN_CANCEL];
    assign select_ev  = press[BTN_SELECT] & ~press[BTN_CONFIRM] & ~press[BTN_CANCEL];

    menu_state_e state_q;
    menu_state_e state_d;
    logic [2:0]  cursor_q;
    logic [2:0]  cursor_d;
    logic [7:0]  actions_q;
    logic [7:0]  actions_d;
    logic        menu_active_q;

`ifdef ACTION_COOLDOWN_EN
    localparam logic [9:0] COOL_LOAD = 10'(COOLDOWN_CYCLES - 1);
    logic [9:0] cool_q;
    logic [9:0] cool_d;
    logic       busy_q;
`endif

    // Menu next-state: the action pulse is computed on the BROWSE->FIRE edge so it is
    // registered and coincides with the FIRE cycle.
    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        actions_d = 8'd0;
`ifdef ACTION_COOLDOWN_EN
        cool_d    = cool_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cursor_d = 3'd0;
                if (select_ev) begin
                    state_d = ST_BROWSE;
                end
            end
            ST_BROWSE: begin
                if (cancel_ev) begin
                    state_d  = ST_IDLE;
                    cursor_d = 3'd0;
                end else if (confirm_ev) begin
                    state_d   = ST_FIRE;
                    actions_d = action_onehot(cursor_q);
                end else if (select_ev) begin
                    cursor_d = cursor_next(cursor_q);
                end
            end
            ST_FIRE: begin
`ifdef ACTION_COOLDOWN_EN
                state_d = ST_COOLDOWN;
                cool_d  = COOL_LOAD;
`else
                state_d = ST_BROWSE;
`endif
            end
            ST_COOLDOWN: begin
`ifdef ACTION_COOLDOWN_EN
                // Presses here are simply not looked at, so nothing is queued.
                if (cool_q == 10'd0) begin
                    state_d = ST_BROWSE;
                end else begin
                    cool_d = cool_q - 10'd1;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d  = ST_IDLE;
                cursor_d = 3'd0;
            end
        endcase
    end

    // State, cursor and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cursor_q      <= 3'd0;
            actions_q     <= 8'd0;
            menu_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cursor_q      <= cursor_d;
            actions_q     <= actions_d;
            menu_active_q <= (state_d != ST_IDLE);
        end
    end

`ifdef ACTION_COOLDOWN_EN
    // Cooldown counter and busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cool_q <= 10'd0;
            busy_q <= 1'b0;
        end else begin
            cool_q <= cool_d;
            busy_q <= (state_d == ST_COOLDOWN);
        end
    end

    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif

    assign actions     = actions_q;
    assign cursor      = cursor_q;
    assign menu_active = menu_active_q;

endmodule
